ser_rx_ctrl: RTL and testbench

Control FSM for the serial-to-parallel receive path. It sits directly upstream of the 8-bit shift/counter datapath and drives that datapath's control inputs. It detects a start bit on the serial line, sequences 8 LSB-first data shifts, checks the stop bit, then presents the assembled byte with a valid/ack handshake. It also counts good frames.

---
 rtl/ser_rx_ctrl_if.sv | 27 ++
 rtl/ser_rx_ctrl.sv | 116 +++++++++++
 tb/tb_ser_rx_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ser_rx_ctrl_if.sv
// Signal bundle between the serial receive controller, its shift/counter
// datapath and the byte consumer.
interface ser_rx_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             serin;
  logic             co;
  logic             ack;
  logic             init_sh;
  logic             ld;
  logic             en_sh;
  logic             en_cnt;
  logic             valid;
  logic             frame_err;
  logic             busy;
  logic [CNT_W-1:0] rx_count;

  modport master (
    input  serin, co, ack,
    output init_sh, ld, en_sh, en_cnt, valid, frame_err, busy, rx_count
  );

  modport slave (
    output serin, co, ack,
    input  init_sh, ld, en_sh, en_cnt, valid, frame_err, busy, rx_count
  );
endinterface

// File: rtl/ser_rx_ctrl.sv
// Receive-side control FSM: start-bit detect, 8 LSB-first shifts paced by the
// datapath carry-out, stop-bit check, valid/ack byte hand-off and frame count.
module ser_rx_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_sh,
  ser_rx_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    STOP  = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             frame_err_r;
  logic             frame_err_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic             count_inc_s;
  logic             init_sh_s;
  logic             ld_s;
  logic             en_sh_s;
  logic             en_cnt_s;
  logic             valid_s;

  // State register
  always_ff @(posedge clk or posedge rst_sh) begin
    if (rst_sh) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and control decode; start-bit strobes are held off during reset
  always_comb begin
    state_nxt_s     = state_r;
    init_sh_s       = 1'b0;
    ld_s            = 1'b0;
    en_sh_s         = 1'b0;
    en_cnt_s        = 1'b0;
    valid_s         = 1'b0;
    count_inc_s     = 1'b0;
    frame_err_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!bus.serin && !rst_sh) begin
          init_sh_s   = 1'b1;
          ld_s        = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        en_sh_s  = 1'b1;
        en_cnt_s = 1'b1;
        if (bus.co) begin
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      STOP: begin
        if (bus.serin) begin
          count_inc_s = 1'b1;
          state_nxt_s = DONE;
        end else begin
          frame_err_nxt_s = 1'b1;
          state_nxt_s     = IDLE;
        end
      end
      DONE: begin
        // Datapath controls stay low so the shifter holds the byte
        valid_s = 1'b1;
        if (bus.ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Frame-error pulse and good-frame counter
  always_ff @(posedge clk or posedge rst_sh) begin
    if (rst_sh) begin
      frame_err_r <= 1'b0;
      count_r     <= '0;
    end else begin
      frame_err_r <= frame_err_nxt_s;
      if (count_inc_s) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign bus.init_sh   = init_sh_s;
  assign bus.ld        = ld_s;
  assign bus.en_sh     = en_sh_s;
  assign bus.en_cnt    = en_cnt_s;
  assign bus.valid     = valid_s;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = (state_r != IDLE);
  assign bus.rx_count  = count_r;

endmodule

// File: tb/tb_ser_rx_ctrl.sv
// Randomized bench for ser_rx_ctrl with a frame-phase reference model and a
// behavioural shift/counter datapath closing the co loop.
module tb_ser_rx_ctrl;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_sh;

  ser_rx_ctrl_if #(.CNT_W(CNT_W)) bus ();

  ser_rx_ctrl #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_sh (rst_sh),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: shifter fills from the MSB so d0 ends in bit 0 after 8 shifts
  logic [7:0] po_sh;
  logic [2:0] dp_cnt;
  always @(posedge clk or posedge rst_sh) begin
    if (rst_sh) begin
      po_sh  <= 8'h00;
      dp_cnt <= 3'd0;
    end else begin
      if (bus.init_sh)    po_sh <= 8'h00;
      else if (bus.en_sh) po_sh <= {bus.serin, po_sh[7:1]};
      if (bus.ld)          dp_cnt <= 3'd0;
      else if (bus.en_cnt) dp_cnt <= dp_cnt + 3'd1;
    end
  end
  assign bus.co = bus.en_cnt && (dp_cnt == 3'd7);

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: m_k = -1 idle, 0..7 data bits taken, 8 stop slot, 9 waiting for ack
  int               m_k     = -1;
  logic [7:0]       m_byte  = 8'h00;
  logic             m_err   = 1'b0;
  logic [CNT_W-1:0] m_count = '0;

  initial begin
    logic [6:0] exp_ctrl;
    forever begin
      @(negedge clk);
      if (rst_sh) begin
        m_k = -1; m_err = 1'b0; m_count = '0;
      end
      exp_ctrl = {(!rst_sh && m_k == -1 && !bus.serin),
                  (!rst_sh && m_k == -1 && !bus.serin),
                  (m_k >= 0 && m_k <= 7),
                  (m_k >= 0 && m_k <= 7),
                  (m_k == 9),
                  m_err,
                  (m_k >= 0)};
      chk("ctrl{init_sh,ld,en_sh,en_cnt,valid,frame_err,busy}",
          {25'd0, bus.init_sh, bus.ld, bus.en_sh, bus.en_cnt, bus.valid, bus.frame_err, bus.busy},
          {25'd0, exp_ctrl});
      chk("rx_count", {24'd0, bus.rx_count}, {24'd0, m_count});
      if (m_k == 9) chk("po_sh", {24'd0, po_sh}, {24'd0, m_byte});
      @(posedge clk);
      if (rst_sh) begin
        m_k = -1; m_err = 1'b0; m_count = '0;
      end else begin
        m_err = 1'b0;
        if (m_k == -1) begin
          if (!bus.serin) begin m_k = 0; m_byte = 8'h00; end
        end else if (m_k <= 7) begin
          m_byte[m_k] = bus.serin;
          m_k++;
        end else if (m_k == 8) begin
          if (bus.serin) begin m_k = 9; m_count++; end
          else begin m_k = -1; m_err = 1'b1; end
        end else begin
          if (bus.ack) m_k = -1;
        end
      end
    end
  end

  task automatic drive(input logic s, input logic a);
    bus.serin = s;
    bus.ack   = a;
    @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, stop bit; returns just after the stop edge
  task automatic frame_body(input logic [7:0] b, input logic stop);
    drive(1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) drive(b[i], 1'($urandom_range(0, 1)));
    drive(stop, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    rst_sh = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_sh = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    rst_sh    = 1'b1;
    bus.serin = 1'b1;
    bus.ack   = 1'b0;
    do_reset();

    // Idle after reset
    repeat (20) drive(1'b1, 1'b0);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_valid", {31'd0, bus.valid}, 32'd0);
    chk("idle_count", {24'd0, bus.rx_count}, 32'd0);

    // Good frame 4D, ack at edge 12
    frame_body(8'h4D, 1'b1);
    chk("good_valid", {31'd0, bus.valid}, 32'd1);
    chk("good_po", {24'd0, po_sh}, 32'h4D);
    chk("good_count", {24'd0, bus.rx_count}, 32'd1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    chk("good_valid_held", {31'd0, bus.valid}, 32'd1);
    drive(1'b1, 1'b1);
    chk("good_valid_fall", {31'd0, bus.valid}, 32'd0);

    // Framing error
    frame_body(8'h4D, 1'b0);
    chk("ferr_pulse", {31'd0, bus.frame_err}, 32'd1);
    chk("ferr_valid", {31'd0, bus.valid}, 32'd0);
    chk("ferr_busy", {31'd0, bus.busy}, 32'd0);
    drive(1'b1, 1'b0);
    chk("ferr_end", {31'd0, bus.frame_err}, 32'd0);
    chk("ferr_count", {24'd0, bus.rx_count}, 32'd1);

    // Hold A5 without ack while serin wiggles
    frame_body(8'hA5, 1'b1);
    repeat (30) drive(1'($urandom_range(0, 1)), 1'b0);
    chk("hold_valid", {31'd0, bus.valid}, 32'd1);
    chk("hold_po", {24'd0, po_sh}, 32'hA5);
    chk("hold_en_sh", {31'd0, bus.en_sh}, 32'd0);
    drive(1'b1, 1'b1);

    // Reset between edge 4 and edge 5, then a clean 3C frame
    drive(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
    rst_sh = 1'b1;
    #2;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_en_sh", {31'd0, bus.en_sh}, 32'd0);
    chk("rst_count", {24'd0, bus.rx_count}, 32'd0);
    @(posedge clk);
    #1;
    rst_sh = 1'b0;
    drive(1'b1, 1'b0);
    frame_body(8'h3C, 1'b1);
    chk("after_rst_po", {24'd0, po_sh}, 32'h3C);
    chk("after_rst_count", {24'd0, bus.rx_count}, 32'd1);
    drive(1'b1, 1'b1);

    // Random frames, random stop bits, ack delays and gaps
    for (int n = 0; n < 60; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      frame_body(b, stop);
      if (stop) begin
        repeat ($urandom_range(0, 3)) drive(1'($urandom_range(0, 1)), 1'b0);
        drive(1'($urandom_range(0, 1)), 1'b1);
      end
      repeat ($urandom_range(0, 2)) drive(1'b1, 1'($urandom_range(0, 1)));
    end

    // 256 back-to-back frames: counter wraps to 0
    drive(1'b1, 1'b0);
    do_reset();
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom);
      frame_body(b, 1'b1);
      chk("b2b_po", {24'd0, po_sh}, {24'd0, b});
      if (n == 254) chk("wrap_pre", {24'd0, bus.rx_count}, 32'd255);
      drive(1'b1, 1'b1);
    end
    chk("wrap_count", {24'd0, bus.rx_count}, 32'd0);
    repeat (3) drive(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
